// File: rtl/winograd_elementwise_mult.sv
// Winograd F(4x4,3x3) element-wise stage: M = U (.) V on 6x6 tiles,
// one row of six signed products per cycle. Optional clamp: WINO_EWM_SAT_EN.
module winograd_elementwise_mult #(
    parameter int DATA_W = 16,
    parameter int PROD_W = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [0:5][0:5][DATA_W-1:0]      u_in,
    input  logic [0:5][0:5][DATA_W-1:0]      v_in,
    output logic [0:5][0:5][PROD_W-1:0]      m_out,
    output logic                             busy,
    output logic                             done,
    output logic                             overflow
);

    localparam int FULL_W = 2 * DATA_W;

`ifdef WINO_EWM_SAT_EN
    // Saturation needs the full product to see out-of-range values.
    localparam int EXT_W = FULL_W;
    localparam logic signed [FULL_W-1:0] P_MAX =
        {{(FULL_W-PROD_W+1){1'b0}}, {(PROD_W-1){1'b1}}};
    localparam logic signed [FULL_W-1:0] P_MIN = ~P_MAX;
`else
    // Wrapping only needs the low PROD_W bits of the product.
    localparam int EXT_W = PROD_W;
`endif

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t                          state;
    logic [2:0]                      row;
    logic [0:5][0:5][DATA_W-1:0]     u_q;
    logic [0:5][0:5][DATA_W-1:0]     v_q;
    logic [0:5][DATA_W-1:0]          u_row;
    logic [0:5][DATA_W-1:0]          v_row;
    logic [0:5][PROD_W-1:0]          prod;

    assign u_row = u_q[row];
    assign v_row = v_q[row];

`ifdef WINO_EWM_SAT_EN
    logic [5:0] clamp_v;
`endif

    for (genvar j = 0; j < 6; j++) begin : g_mul
        logic signed [EXT_W-1:0] a;
        logic signed [EXT_W-1:0] b;
        logic signed [EXT_W-1:0] p;

        // Explicit sign extension keeps the multiply width exact.
        assign a = {{(EXT_W-DATA_W){u_row[j][DATA_W-1]}}, u_row[j]};
        assign b = {{(EXT_W-DATA_W){v_row[j][DATA_W-1]}}, v_row[j]};
        assign p = a * b;

`ifdef WINO_EWM_SAT_EN
        logic hi;
        logic lo;

        assign hi = (p > P_MAX);
        assign lo = (p < P_MIN);
        assign clamp_v[j] = hi | lo;
        assign prod[j] = hi ? P_MAX[PROD_W-1:0] :
                         lo ? P_MIN[PROD_W-1:0] :
                              p[PROD_W-1:0];
`else
        assign prod[j] = p;
`endif
    end

    // Tile sequencer: snapshot on start, then write one product row per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            row   <= 3'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            u_q   <= '0;
            v_q   <= '0;
            m_out <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        u_q   <= u_in;
                        v_q   <= v_in;
                        row   <= 3'd0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    m_out[row] <= prod;
                    if (row == 3'd5) begin
                        row   <= 3'd0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        row <= row + 3'd1;
                    end
                end
            endcase
        end
    end

`ifdef WINO_EWM_SAT_EN
    logic ovf_q;
    logic accept;
    logic calc;

    assign accept = (state == IDLE) && start;
    assign calc   = (state == CALC);

    // Sticky clamp flag, cleared when a new tile is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if (calc && (|clamp_v)) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_winograd_elementwise_mult.sv
// Directed bench for winograd_elementwise_mult (PROD_W 32 and 24).
// Expectations for the 24-bit instance follow WINO_EWM_SAT_EN.
module tb_winograd_elementwise_mult;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [0:5][0:5][15:0] u;
    logic [0:5][0:5][15:0] v;
    logic [0:5][0:5][31:0] m;
    logic busy, done, ovf;
    logic [0:5][0:5][23:0] m24;
    logic busy24, done24, ovf24;

    int total = 0;
    int bad = 0;
    int exp_m [6][6];
    int tu [5][6][6];
    int tv [5][6][6];

    winograd_elementwise_mult #(.DATA_W(16), .PROD_W(32)) dut (
        .clk(clk), .rst(rst), .start(start),
        .u_in(u), .v_in(v), .m_out(m),
        .busy(busy), .done(done), .overflow(ovf)
    );

    winograd_elementwise_mult #(.DATA_W(16), .PROD_W(24)) dut24 (
        .clk(clk), .rst(rst), .start(start),
        .u_in(u), .v_in(v), .m_out(m24),
        .busy(busy24), .done(done24), .overflow(ovf24)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int uv, input int vv);
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++) begin
                u[i][j] = 16'(uv);
                v[i][j] = 16'(vv);
            end
    endtask

    task automatic set_exp(input int e);
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                exp_m[i][j] = e;
    endtask

    task automatic check_tile(input string tag);
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                check($sformatf("%s[%0d][%0d]", tag, i, j),
                      longint'($signed(m[i][j])), longint'(exp_m[i][j]));
    endtask

    task automatic check_tile24(input string tag, input int e);
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                check($sformatf("%s[%0d][%0d]", tag, i, j),
                      longint'($signed(m24[i][j])), longint'(e));
    endtask

    // start pulse, then advance to just after E6
    task automatic run_tile;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        fill(0, 0);
        repeat (3) @(posedge clk);
        #1;
        set_exp(0);
        check_tile("rst_m");
        rst = 1'b0;

        // idle after reset with no start
        for (int k = 0; k < 20; k++) begin
            tick();
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_ovf", ovf, 0);
            check("idle_ovf24", ovf24, 0);
        end
        check_tile("idle_m");

        // uniform 3 * -5
        fill(3, -5);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check("neg_busy", busy, 1);
            check("neg_done", done, 0);
            tick();
        end
        check("neg_busy_end", busy, 0);
        check("neg_done_end", done, 1);
        set_exp(-15);
        check_tile("neg");
        tick();
        check("neg_done_clr", done, 0);

        // ramp u, v=2: rows appear one per cycle
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++) begin
                u[i][j] = 16'(6 * i + j);
                v[i][j] = 16'(2);
            end
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ramp_e0_row0", longint'($signed(m[0][0])), -15);
        for (int r = 0; r < 6; r++) begin
            tick();
            for (int j = 0; j < 6; j++)
                check($sformatf("ramp_row%0d_%0d", r, j),
                      longint'($signed(m[r][j])), 2 * (6 * r + j));
            for (int rr = r + 1; rr < 6; rr++)
                check($sformatf("ramp_old%0d", rr),
                      longint'($signed(m[rr][0])), -15);
        end
        check("ramp_done", done, 1);

        // start held 30 cycles, inputs change every cycle
        for (int k = 0; k < 36; k++) begin
            start = (k < 30);
            for (int i = 0; i < 6; i++)
                for (int j = 0; j < 6; j++) begin
                    u[i][j] = 16'(k * 7 + i - j);
                    v[i][j] = 16'(3 - k + i * j);
                    if (k % 7 == 0 && k < 30) begin
                        tu[k / 7][i][j] = k * 7 + i - j;
                        tv[k / 7][i][j] = 3 - k + i * j;
                    end
                end
            tick();
            check($sformatf("pipe_done_%0d", k), done, (k % 7 == 6));
            check($sformatf("pipe_busy_%0d", k), busy,
                  (k < 35) && (k % 7 != 6));
            if (k % 7 == 6) begin
                for (int i = 0; i < 6; i++)
                    for (int j = 0; j < 6; j++)
                        exp_m[i][j] = tu[k / 7][i][j] * tv[k / 7][i][j];
                check_tile($sformatf("pipe_t%0d", k / 7));
            end
        end
        start = 1'b0;

        // reset after row 3 written
        fill(1, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("abort_row3", longint'($signed(m[3][2])), 1);
        rst = 1'b1;
        #1;
        set_exp(0);
        check_tile("abort_m");
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("abort_nodone", done, 0);
            check("abort_nobusy", busy, 0);
            tick();
        end
        check_tile("abort_hold");
        fill(7, 7);
        run_tile();
        check("seven_done", done, 1);
        set_exp(49);
        check_tile("seven");

        // extreme operands, 24-bit product instance
        fill(-32768, -32768);
        run_tile();
        check("ext_done", done, 1);
        check("ext_done24", done24, 1);
        set_exp(1073741824);
        check_tile("ext32");
        check("ext_ovf32", ovf, 0);
`ifdef WINO_EWM_SAT_EN
        check_tile24("ext24", 8388607);
        check("ext_ovf24", ovf24, 1);
`else
        check_tile24("ext24", 0);
        check("ext_ovf24", ovf24, 0);
`endif
        tick();
`ifdef WINO_EWM_SAT_EN
        check("ovf24_sticky", ovf24, 1);
`else
        check("ovf24_tied", ovf24, 0);
`endif
        fill(1, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ovf24_clr", ovf24, 0);
        repeat (6) tick();
        check("clr_done24", done24, 1);
        check_tile24("clr24", 1);
        check("clr_ovf24_end", ovf24, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
